exec_writeback_unit: RTL and testbench
======================================

// Module: exec_writeback_unit
// PURPOSE
//  Decode/execute/write-back stage feeding the 8x12 register file. Accepts one
//  12-bit instruction per handshake and drives the file's two read addresses.
//  Captures the read data, computes an ALU result, then writes it back through
//  the file's write port. Non-pipelined: one instruction in flight.
// PARAMETERS
//  DATA_W  12  datapath / register width
//  ADDR_W   3  register address width (8 registers)
// PORTS
//  clk        in   1       single clock, all state on posedge
//  reset      in   1       synchronous, active-high
//  instValid  in   1       instruction offered
//  instReady  out  1       block can accept an instruction
//  instr      in   12      {op[11:9], rd[8:6], rs1[5:3], rs2[2:0]}
//  read1Addr  out  3       to register file read port 1 (= rs1)
//  read2Addr  out  3       to register file read port 2 (= rs2)
//  readData1  in   12      from register file port 1, combinational read
//  readData2  in   12      from register file port 2, combinational read
//  writeEn    out  1       register file write enable; the write commits on that clk edge
//  writeAddr  out  3       write-back register (= rd)
//  writeData  out  12      write-back value
//  done       out  1       one-cycle pulse in the WRITE cycle
//  resultZero out  1       registered; 1 if last written result == 0
// BEHAVIOUR
//  Reset: state=IDLE; instr latch, opA, opB, result, mulCount=0; read1Addr=read2Addr=0.
//   writeAddr=0, writeData=0, writeEn=0, done=0, resultZero=0.
//   instReady=0 while reset is high.
//  FSM IDLE -> READ -> EXEC -> WRITE -> IDLE.
//  IDLE:  instReady=1. If instValid&&instReady at the edge: latch instr, go READ.
//   instValid while not in IDLE is ignored; the source holds it.
//  READ:  read1Addr/read2Addr = latched rs1/rs2, held stable until IDLE.
//   At the edge, opA<=readData1 and opB<=readData2; go EXEC.
//  EXEC:  single-cycle ops: result computed, go WRITE.
//   op 0 ADD  opA+opB, mod 2^12
//   op 1 SUB  opA-opB, mod 2^12 (wrap, no flag)
//   op 2 AND
//   op 3 OR
//   op 4 XOR
//   op 5 SLT  signed two's-complement; result 1 if opA<opB, else 0
//   op 6 MOV  opA
//   op 7 MUL  see CONFIGURATION
//  WRITE: writeEn=1, writeAddr=rd, writeData=result, done=1 for exactly one cycle;
//   resultZero updated at the same edge; go IDLE.
//  Latency: accept edge -> WRITE cycle is 3 cycles (READ, EXEC, WRITE). Throughput 1 per 4 cycles.
//  rd==rs1/rs2: legal; operands are captured in READ, before the write.
//  Reset mid-operation: return to IDLE at that edge, no write, writeEn/done low next cycle.
// CONFIGURATION
//  ALU_MUL_EN defined:
//   op 7 = iterative shift-add MUL, low 12 bits of opA*opB.
//   EXEC lasts exactly 12 cycles; mulCount runs 0..11, then WRITE.
//   Accept -> WRITE = 14 cycles.
//  ALU_MUL_EN undefined:
//   op 7 = NOP, with single-cycle EXEC.
//   WRITE cycle still pulses done, but writeEn stays 0 and resultZero is unchanged.
// TESTING
//  R1=5, R2=7, ADD rd=3 -> writeEn in 3rd cycle after accept, R3=12, resultZero=0.
//  R1=3, R2=5, SUB rd=4 -> writeData=0xFFE. XOR R1,R1 -> 0, resultZero=1.
//  R1=0x800, R2=1, SLT -> 1. SLT R2,R1 -> 0.
//  MUL_EN: R1=0x012, R2=0x00A -> 0x0B4 after 12 EXEC cycles. Without the macro: no write, done pulses.
//  instValid held high continuously -> instReady only in IDLE; exactly one accept per 4 cycles.
//  reset asserted in EXEC (mid-MUL) -> writeEn never asserted, state IDLE; instReady=1 the cycle after reset drops.

Source files
------------

// File: rtl/exec_writeback_unit_if.sv
// Bus bundle between exec_writeback_unit, its instruction source and the
// 8x12 register file. The unit connects through the slave modport; the
// source / register-file side connects through the master modport.
//
// Handshake: an instruction transfers on a rising clk edge where instValid
// and instReady are both high. instValid is held by the source until that
// edge; instReady is high only while the unit is idle and out of reset.
interface exec_writeback_unit_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 3
);
    logic              instValid;
    logic              instReady;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] read1Addr;
    logic [ADDR_W-1:0] read2Addr;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic              writeEn;
    logic [ADDR_W-1:0] writeAddr;
    logic [DATA_W-1:0] writeData;
    logic              done;
    logic              resultZero;

    modport master (
        output instValid, instr, readData1, readData2,
        input  instReady, read1Addr, read2Addr, writeEn, writeAddr,
               writeData, done, resultZero
    );

    modport slave (
        input  instValid, instr, readData1, readData2,
        output instReady, read1Addr, read2Addr, writeEn, writeAddr,
               writeData, done, resultZero
    );
endinterface

// File: rtl/exec_writeback_unit.sv
// Non-pipelined decode/execute/write-back stage for an 8x12 register file.
// One instruction in flight: IDLE -> READ -> EXEC -> WRITE -> IDLE.
// Instruction format: {op[11:9], rd[8:6], rs1[5:3], rs2[2:0]}.
// Optional feature macro: ALU_MUL_EN. When defined, op 7 is a 12-cycle
// shift-add multiply (low 12 bits of the product); when undefined, op 7 is a
// NOP that still pulses done but never writes the register file.
// state_o exposes the FSM state for observation.
module exec_writeback_unit #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    exec_writeback_unit_if.slave bus,
    output logic [1:0]           state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_MOV = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] op_a_q, op_b_q;
    logic [DATA_W-1:0] result_q;
    logic              write_en_q;
    logic [ADDR_W-1:0] write_addr_q;
    logic              done_q;
    logic              result_zero_q;
    logic [DATA_W-1:0] alu_res;
    logic              accept;
    logic [2:0]        op;
    logic [ADDR_W-1:0] rd;

    assign op = instr_q[11:9];
    assign rd = instr_q[8:6];

    // Ready only while idle and out of reset.
    assign bus.instReady = (state_q == S_IDLE) && !reset;
    assign accept        = bus.instValid && bus.instReady;

    // Read addresses come straight from the latched instruction, so they stay
    // stable from READ until the next accept.
    assign bus.read1Addr  = instr_q[5:3];
    assign bus.read2Addr  = instr_q[2:0];
    assign bus.writeEn    = write_en_q;
    assign bus.writeAddr  = write_addr_q;
    assign bus.writeData  = result_q;
    assign bus.done       = done_q;
    assign bus.resultZero = result_zero_q;
    assign state_o        = state_q;

`ifdef ALU_MUL_EN
    localparam logic [3:0] MUL_LAST = 4'd11;

    logic [3:0]        mul_count_q;
    logic [DATA_W-1:0] mul_sel;
    logic [DATA_W-1:0] mul_acc;
    logic              is_mul;

    assign is_mul = (op == OP_MUL);

    // One shift-add step: add opA<<i when bit i of opB is set.
    always_comb begin
        mul_sel = {{(DATA_W-1){1'b0}}, 1'b1} << mul_count_q;
        mul_acc = result_q;
        if (|(op_b_q & mul_sel)) begin
            mul_acc = result_q + (op_a_q << mul_count_q);
        end
    end
`endif

    // Single-cycle ALU operations on the captured operands.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = op_a_q + op_b_q;
            OP_SUB:  alu_res = op_a_q - op_b_q;
            OP_AND:  alu_res = op_a_q & op_b_q;
            OP_OR:   alu_res = op_a_q | op_b_q;
            OP_XOR:  alu_res = op_a_q ^ op_b_q;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a_q) < $signed(op_b_q))};
            OP_MOV:  alu_res = op_a_q;
            default: alu_res = '0;
        endcase
    end

    // Next-state logic; EXEC holds for the multiply only.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
`ifdef ALU_MUL_EN
            S_EXEC:  if (!is_mul || (mul_count_q == MUL_LAST)) state_d = S_WRITE;
`else
            S_EXEC:  state_d = S_WRITE;
`endif
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output registers, advanced per FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            instr_q       <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            result_q      <= '0;
            write_en_q    <= 1'b0;
            write_addr_q  <= '0;
            done_q        <= 1'b0;
            result_zero_q <= 1'b0;
`ifdef ALU_MUL_EN
            mul_count_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) instr_q <= bus.instr;
                end
                S_READ: begin
                    op_a_q <= bus.readData1;
                    op_b_q <= bus.readData2;
`ifdef ALU_MUL_EN
                    // Multiply accumulates into result, so start it from zero.
                    if (is_mul) result_q <= '0;
                    mul_count_q <= '0;
`endif
                end
                S_EXEC: begin
`ifdef ALU_MUL_EN
                    if (is_mul) begin
                        result_q    <= mul_acc;
                        mul_count_q <= mul_count_q + 4'd1;
                        if (mul_count_q == MUL_LAST) begin
                            write_en_q   <= 1'b1;
                            write_addr_q <= rd;
                            done_q       <= 1'b1;
                        end
                    end else begin
                        result_q     <= alu_res;
                        write_en_q   <= 1'b1;
                        write_addr_q <= rd;
                        done_q       <= 1'b1;
                    end
`else
                    // Without the multiplier, op 7 completes but leaves the
                    // previous result and resultZero untouched.
                    write_addr_q <= rd;
                    done_q       <= 1'b1;
                    if (op != OP_MUL) begin
                        result_q   <= alu_res;
                        write_en_q <= 1'b1;
                    end
`endif
                end
                S_WRITE: begin
                    write_en_q <= 1'b0;
                    done_q     <= 1'b0;
                    if (write_en_q) result_zero_q <= (result_q == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_writeback_unit.sv
// Randomized bench for exec_writeback_unit with a register-file model and an
// arithmetic reference model of the instruction set.
module tb_exec_writeback_unit;

    logic       clk;
    logic       reset;
    logic [1:0] state_o;

    exec_writeback_unit_if wb_if ();

    exec_writeback_unit dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (wb_if),
        .state_o (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- register file (environment) ----------------
    logic [11:0] rf [8];
    logic        pre_we;
    logic [2:0]  pre_addr;
    logic [11:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (wb_if.writeEn) rf[wb_if.writeAddr] <= wb_if.writeData;
    end

    assign wb_if.readData1 = rf[wb_if.read1Addr];
    assign wb_if.readData2 = rf[wb_if.read2Addr];

    // ---------------- reference model / scoreboard ----------------
    int          ref_rf [8];
    bit          exp_rz;
    logic [11:0] exp_q [$];
    int          n_checks;
    int          n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int sx12(input int v);
        return (v >= 2048) ? v - 4096 : v;
    endfunction

    // Result of one instruction from plain arithmetic; wr=0 means no write.
    function automatic int model(input int op, input int a, input int b, output bit wr);
        wr = 1'b1;
        case (op)
            0: return (a + b) % 4096;
            1: return ((a - b) % 4096 + 4096) % 4096;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (sx12(a) < sx12(b)) ? 1 : 0;
            6: return a;
            default: begin
`ifdef ALU_MUL_EN
                return (a * b) % 4096;
`else
                wr = 1'b0;
                return 0;
`endif
            end
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_reg(input int a, input int v);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a[2:0];
        pre_data = v[11:0];
        @(negedge clk);
        pre_we   = 1'b0;
        ref_rf[a] = v;
    endtask

    task automatic wait_ready(input string tag);
        int cyc;
        cyc = 0;
        while (wb_if.instReady !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_eq(tag, wb_if.instReady, 1'b1);
    endtask

    task automatic run_instr(input int op, input int rd, input int rs1, input int rs2);
        int          exp, lat_exp, cyc;
        bit          wr, seen, early;
        logic [11:0] word;
        logic [11:0] exp_data;
        exp     = model(op, ref_rf[rs1], ref_rf[rs2], wr);
        lat_exp = 3;
`ifdef ALU_MUL_EN
        if (op == 7) lat_exp = 14;
`endif
        if (wr) exp_q.push_back(exp[11:0]);
        wait_ready("ready_idle");
        word = {op[2:0], rd[2:0], rs1[2:0], rs2[2:0]};
        wb_if.instr     = word;
        wb_if.instValid = 1'b1;
        @(negedge clk);
        check_eq("ready_busy", wb_if.instReady, 1'b0);
        check_eq("read1_addr", wb_if.read1Addr, rs1[2:0]);
        check_eq("read2_addr", wb_if.read2Addr, rs2[2:0]);
        // The source may keep offering while busy; it must be ignored.
        wb_if.instValid = 1'($urandom_range(0, 1));
        seen  = 1'b0;
        early = 1'b0;
        cyc   = 1;
        while (!seen && cyc <= 20) begin
            if (wb_if.done === 1'b1) seen = 1'b1;
            else begin
                if (wb_if.writeEn !== 1'b0) early = 1'b1;
                @(negedge clk);
                cyc++;
            end
        end
        wb_if.instValid = 1'b0;
        check_eq("done_seen", seen, 1'b1);
        check_eq("latency", cyc, lat_exp);
        check_eq("early_we", early, 1'b0);
        check_eq("write_en", wb_if.writeEn, wr);
        if (wr) begin
            exp_data = exp_q.pop_front();
            check_eq("write_addr", wb_if.writeAddr, rd[2:0]);
            check_eq("write_data", wb_if.writeData, exp_data);
            ref_rf[rd] = exp;
            exp_rz     = (exp == 0);
        end
        @(negedge clk);
        check_eq("done_pulse", wb_if.done, 1'b0);
        check_eq("we_pulse", wb_if.writeEn, 1'b0);
        check_eq("result_zero", wb_if.resultZero, exp_rz);
        check_eq("ready_after", wb_if.instReady, 1'b1);
    endtask

    task automatic run_throughput();
        int last, n_acc;
        wait_ready("tp_start");
        wb_if.instr     = {3'd6, 3'd1, 3'd1, 3'd0};
        wb_if.instValid = 1'b1;
        last  = -1;
        n_acc = 0;
        for (int c = 0; c < 24; c++) begin
            if (wb_if.instReady === 1'b1) begin
                n_acc++;
                if (last >= 0) check_eq("tp_gap", c - last, 4);
                last = c;
            end
            @(negedge clk);
        end
        wb_if.instValid = 1'b0;
        check_eq("tp_count", n_acc, 6);
        exp_rz = (ref_rf[1] == 0);
        check_eq("tp_ready_end", wb_if.instReady, 1'b1);
        check_eq("tp_rz", wb_if.resultZero, exp_rz);
    endtask

    task automatic run_reset_mid_exec();
        bit we_seen;
        wait_ready("rst_start");
        wb_if.instr     = {3'd7, 3'd2, 3'd1, 3'd2};
        wb_if.instValid = 1'b1;
        @(negedge clk);
        wb_if.instValid = 1'b0;
        we_seen = (wb_if.writeEn !== 1'b0);
        @(negedge clk);
        we_seen = we_seen | (wb_if.writeEn !== 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_state", state_o, 2'd0);
        check_eq("rst_we", wb_if.writeEn, 1'b0);
        check_eq("rst_done", wb_if.done, 1'b0);
        check_eq("rst_ready", wb_if.instReady, 1'b0);
        check_eq("rst_rz", wb_if.resultZero, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_ready_after", wb_if.instReady, 1'b1);
        we_seen = we_seen | (wb_if.writeEn !== 1'b0);
        check_eq("rst_no_write", we_seen, 1'b0);
        exp_rz = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks        = 0;
        n_errors        = 0;
        exp_rz          = 1'b0;
        reset           = 1'b1;
        pre_we          = 1'b0;
        pre_addr        = '0;
        pre_data        = '0;
        wb_if.instValid = 1'b0;
        wb_if.instr     = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_ready", wb_if.instReady, 1'b0);
        check_eq("reset_we", wb_if.writeEn, 1'b0);
        check_eq("reset_done", wb_if.done, 1'b0);
        check_eq("reset_rz", wb_if.resultZero, 1'b0);
        check_eq("reset_r1addr", wb_if.read1Addr, 3'd0);
        check_eq("reset_r2addr", wb_if.read2Addr, 3'd0);
        check_eq("reset_waddr", wb_if.writeAddr, 3'd0);
        check_eq("reset_wdata", wb_if.writeData, 12'd0);
        check_eq("reset_state", state_o, 2'd0);
        for (int r = 0; r < 8; r++) set_reg(r, $urandom_range(0, 4095));
        reset = 1'b0;
        @(negedge clk);

        // Directed cases.
        set_reg(1, 5);     set_reg(2, 7);
        run_instr(0, 3, 1, 2);
        set_reg(1, 3);     set_reg(2, 5);
        run_instr(1, 4, 1, 2);
        run_instr(4, 5, 1, 1);
        set_reg(1, 'h800); set_reg(2, 1);
        run_instr(5, 6, 1, 2);
        run_instr(5, 6, 2, 1);
        set_reg(1, 'h012); set_reg(2, 'h00A);
        run_instr(7, 7, 1, 2);
        run_instr(0, 1, 1, 1);
        run_instr(2, 0, 3, 4);
        run_instr(3, 2, 3, 4);
        run_instr(6, 3, 0, 5);
        run_throughput();
        run_reset_mid_exec();

        // Randomized instructions with occasional corner-value register loads.
        for (int i = 0; i < 40; i++) begin
            if ((i % 5) == 0) begin
                case ($urandom_range(0, 3))
                    0:       set_reg($urandom_range(0, 7), 0);
                    1:       set_reg($urandom_range(0, 7), 'h800);
                    2:       set_reg($urandom_range(0, 7), 'hFFF);
                    default: set_reg($urandom_range(0, 7), $urandom_range(0, 4095));
                endcase
            end
            run_instr($urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 7));
        end

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
